// File: rtl/alu_issue.sv
// ID->EX issue stage: decodes one MIPS instruction per cycle into ALU op/operands
// and hands it to EX through a two-entry skid buffer with a registered in_ready.
module alu_issue (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [31:0] out_v1,
  output logic [31:0] out_v2,
  output logic [4:0]  out_dst,
  output logic        out_we,
  output logic        out_mem_rd,
  output logic        out_mem_wr,
  output logic [31:0] out_store_val,
  output logic        out_illegal
);

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_ADD  = 4'b1100;
  localparam logic [3:0] ALU_SUB  = 4'b1110;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  dst;
    logic        we;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] store_val;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [4:0]  unused_rs_idx;

  assign opcode        = in_instr[31:26];
  assign unused_rs_idx = in_instr[25:21];
  assign rt_idx        = in_instr[20:16];
  assign rd_idx        = in_instr[15:11];
  assign shamt         = in_instr[10:6];
  assign funct         = in_instr[5:0];
  assign imm           = in_instr[15:0];
  assign imm_sext      = {{16{imm[15]}}, imm};
  assign imm_zext      = {16'b0, imm};

  entry_t     entry_d;
  logic       illegal_d;

  always_comb begin
    entry_d   = '0;
    illegal_d = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        entry_d.dst = rd_idx;
        entry_d.we  = 1'b1;
        entry_d.v1  = in_rs_val;
        entry_d.v2  = in_rt_val;
        case (funct)
          FN_SLL:  begin entry_d.op = ALU_SLL; entry_d.v1 = {27'b0, shamt}; end
          FN_SRL:  begin entry_d.op = ALU_SRL; entry_d.v1 = {27'b0, shamt}; end
          FN_SRA:  begin entry_d.op = ALU_SRA; entry_d.v1 = {27'b0, shamt}; end
          FN_SLLV: entry_d.op = ALU_SLL;
          FN_SRLV: entry_d.op = ALU_SRL;
          FN_SRAV: entry_d.op = ALU_SRA;
          FN_ADD, FN_ADDU: entry_d.op = ALU_ADD;
          FN_SUB, FN_SUBU: entry_d.op = ALU_SUB;
          FN_AND:  entry_d.op = ALU_AND;
          FN_OR:   entry_d.op = ALU_OR;
          FN_XOR:  entry_d.op = ALU_XOR;
          FN_SLT:  entry_d.op = ALU_SLT;
          default: illegal_d = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI, OPC_LUI, OPC_LW, OPC_SW: begin
        entry_d.dst = rt_idx;
        entry_d.we  = 1'b1;
        entry_d.v1  = in_rs_val;
        entry_d.v2  = imm_sext;
        case (opcode)
          OPC_ADDI, OPC_ADDIU: entry_d.op = ALU_ADD;
          OPC_SLTI: entry_d.op = ALU_SLT;
          OPC_ANDI: begin entry_d.op = ALU_AND; entry_d.v2 = imm_zext; end
          OPC_ORI:  begin entry_d.op = ALU_OR;  entry_d.v2 = imm_zext; end
          OPC_XORI: begin entry_d.op = ALU_XOR; entry_d.v2 = imm_zext; end
          OPC_LUI:  begin entry_d.op = ALU_PASS; entry_d.v2 = {imm, 16'b0}; end
          OPC_LW:   begin entry_d.op = ALU_ADD; entry_d.mem_rd = 1'b1; end
          OPC_SW: begin
            entry_d.op        = ALU_ADD;
            entry_d.mem_wr    = 1'b1;
            entry_d.we        = 1'b0;
            entry_d.store_val = in_rt_val;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase

    // Unsupported encodings travel down as a harmless pass-through that never writes back.
    if (illegal_d) begin
      entry_d         = '0;
      entry_d.illegal = 1'b1;
      entry_d.op      = ALU_PASS;
      entry_d.v1      = in_rs_val;
    end

    if (entry_d.dst == 5'd0) begin
      entry_d.we = 1'b0;
    end
  end

  buf_state_t state_q;
  entry_t     out_q;
  entry_t     skid_q;
  logic       out_valid_q;
  logic       in_ready_q;
  logic       accept;
  logic       drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // in_ready_q tracks "skid entry free" for the next cycle, so back-pressure never
  // propagates combinationally from out_ready to in_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_q       <= entry_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_q     <= entry_d;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (accept && drain) begin
            out_q <= entry_d;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_op        = out_q.op;
  assign out_v1        = out_q.v1;
  assign out_v2        = out_q.v2;
  assign out_dst       = out_q.dst;
  assign out_we        = out_q.we;
  assign out_mem_rd    = out_q.mem_rd;
  assign out_mem_wr    = out_q.mem_wr;
  assign out_store_val = out_q.store_val;
  assign out_illegal   = out_q.illegal;

endmodule

// File: doc/alu_issue.md
# alu_issue

Registered ID→EX issue stage for the MIPS pipeline. Each cycle it takes one decoded-register-read instruction (raw word plus rs/rt values), generates the 4-bit ALU opcode and the two ALU operands, and presents them to the execute stage through a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered, so stall back-pressure never forms a combinational path. It is the producer end of the ALU `op`/`v1`/`v2` interface.

## Interface
- No parameters; all widths are fixed by the MIPS32 datapath.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous kill of all held entries (branch redirect).
- `in_valid` in 1: ID presents an instruction.
- `in_ready` out 1: stage can accept; driven directly from a register.
- `in_instr` in 32: raw instruction word.
- `in_rs_val`, `in_rt_val` in 32 each: register-file values of rs and rt.
- `out_valid` out 1: EX entry valid.
- `out_ready` in 1: EX accepts this cycle.
- `out_op` out 4: ALU opcode.
- `out_v1`, `out_v2` out 32: ALU operands.
- `out_dst` out 5: destination register.
- `out_we` out 1: register write enable.
- `out_mem_rd`, `out_mem_wr` out 1 each: lw / sw.
- `out_store_val` out 32: rt value for sw.
- `out_illegal` out 1: unsupported encoding; ALU fields forced to pass-through (`op`=1111, `v2`=0), `we`=0.

## Operation
- Decode is combinational on the input side; results are captured in the output register or the skid register.
- R-type (opcode 000000), keyed on funct:
  - sll 000000 → op 0000; srl 000010 → 0010; sra 000011 → 0011. `v1`={27'b0,shamt}, `v2`=rt.
  - sllv 000100 → 0000; srlv 000110 → 0010; srav 000111 → 0011. `v1`=rs, `v2`=rt.
  - add/addu → 1100; sub/subu → 1110; and → 1000; or → 1001; xor → 1010; slt → 0110. `v1`=rs, `v2`=rt.
  - Destination is rd.
- I-type, destination rt:
  - addi/addiu → 1100, sign-extended imm; slti → 0110, sign-extended.
  - andi → 1000, ori → 1001, xori → 1010, all zero-extended.
  - lui → 1111, `v2`={imm,16'b0}.
  - lw 100011 → 1100, `mem_rd`=1; sw 101011 → 1100, `mem_wr`=1, `we`=0, `store_val`=rt.
  - For I-type, `v1`=rs and `v2`=extended imm.
- Any other encoding → `illegal`=1.
- `out_we` is forced to 0 whenever `out_dst`=0.
- Buffer states (`out_valid`, `skid_full`): EMPTY(0,0), ONE(1,0), FULL(1,1). Transitions on each edge:
  - EMPTY: accept → ONE.
  - ONE: accept with no drain → FULL, new data to skid. Accept with drain → ONE, new data to out. Drain with no accept → EMPTY.
  - FULL: drain → ONE, skid moves to out. Otherwise hold.
- `in_ready` = !skid_full, registered.
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- `flush` has priority over everything: next state EMPTY and `in_ready`=1. An instruction handshaken in the same cycle as `flush` is discarded.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1; every data output 0, including `out_op`=0000.
- Latency is 1 cycle: data accepted at edge N is visible on `out_*` after edge N.
- Output data holds stable while `out_valid`=1 and `out_ready`=0.
- Order is preserved; no entry is dropped or duplicated except by `flush`.
- Throughput is 1 instruction/cycle while `out_ready`=1.
- FULL → `in_ready`=0 from the following cycle. After one drain, `in_ready` returns to 1 the next cycle.
- Reset asserted mid-operation clears both entries immediately (asynchronous), with no pending handshake.

## Test plan
- Reset, then `add $3,$1,$2` (0x00221820) with rs=5, rt=7, `out_ready`=1 → next cycle: `op`=1100, `v1`=5, `v2`=7, `dst`=3, `we`=1.
- `sra $4,$5,3` (0x000520C3), rt=0x80000000 → `op`=0011, `v1`=3, `v2`=0x80000000. `addi $2,$0,-1` → `op`=1100, `v2`=0xFFFFFFFF. `ori` with imm 0xFFFF → `v2`=0x0000FFFF.
- `lui $1,0x1234` → `op`=1111, `v2`=0x12340000. `sw` → `mem_wr`=1, `we`=0, `store_val`=rt. Opcode 111111 → `illegal`=1.
- Hold `out_ready`=0 and present 3 back-to-back instructions A, B, C → A and B accepted, `in_ready`=0 the cycle after B. Release → A, B, C appear in order on consecutive cycles.
- FULL state plus `flush`=1 together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, and the flushed instruction never appears. Pull `resetn` low mid-stall → outputs 0 immediately.
